password_lock_ctrl: RTL
=======================

Name: password_lock_ctrl

Overview:
- Main controller of the password-lock design. It sits between the keypad decoder and the LED/7-segment display block.
- Takes one-cycle key events and sequences the lock through its work states: set password, input password, compare, success hold, freeze after 3 failures.
- Drives exactly the state, buffer, count, failure and accept signals the display block consumes.

Parameters:
- FREEZE_CYCLES, 500_000_000, cycles spent in FREEZED before auto-unlock (5 s at 100 MHz).
- SUCCESS_CYCLES, 300_000_000, cycles spent in MATCH_OK before returning to SETCODE_FINISH.
- TIMER_W, 32, width of the shared down-counter; must hold max(FREEZE_CYCLES, SUCCESS_CYCLES).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- key_valid  in  1  one-cycle pulse: key_code is valid.
- key_code  in  4  0-9 digit; A confirm; B backspace; C set/change password; D cancel; E/F ignored.
- current_work_state  out  3  IDLE=000, SETING_CODE=001, SETCODE_FINISH=010, INPUTING_PASSWORD=011, MATCH_SUCCESS=100, FREEZED=101.
- password_input  out  12  entry buffer; first digit in [11:8], second in [7:4], third in [3:0].
- input_count  out  3  digits currently in the buffer, range 0..3.
- failure_times  out  2  consecutive mismatches, range 0..3.
- success_input  out  1  one-cycle pulse: the last key was accepted.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state IDLE; password_input 0, input_count 0, failure_times 0, success_input 0.
  - stored password 0; pw_valid 0; timer 0.
- Timing: all outputs are registered. The response to key_valid appears on the next clk edge, so latency is 1 cycle.
- success_input is 1 for exactly one cycle after any accepted key. Ignored keys give 0.
- Digit rule (SETING_CODE and INPUTING_PASSWORD):
  - count<3: write the digit into nibble index count (0 maps to [11:8]), then count+1.
  - count==3: ignore the digit.
- Backspace rule (same two states):
  - count>0: count-1 and clear that nibble.
  - count==0: ignore.
- IDLE:
  - C: go to SETING_CODE; clear buffer and count.
  - All other keys: ignore.
- SETING_CODE:
  - Digit and backspace follow the rules above.
  - A with count==3: stored password <= buffer, pw_valid=1, failure_times=0, clear buffer, go to SETCODE_FINISH.
  - A with count<3: ignore.
  - D: clear buffer; go to SETCODE_FINISH if pw_valid, else IDLE.
- SETCODE_FINISH:
  - Digit: go to INPUTING_PASSWORD with that digit loaded ([11:8]=digit, count=1).
  - All other keys: ignore.
- INPUTING_PASSWORD:
  - Digit and backspace follow the rules above.
  - A with count==3, match: failure_times=0, load timer with SUCCESS_CYCLES-1, go to MATCH_SUCCESS.
  - A with count==3, mismatch: failure_times+1. If the new value is 3, load timer with FREEZE_CYCLES-1 and go to FREEZED; otherwise go to SETCODE_FINISH.
  - Both A outcomes clear buffer and count.
  - D: clear buffer; go to SETCODE_FINISH.
- MATCH_SUCCESS:
  - Timer decrements each cycle. At 0, go to SETCODE_FINISH.
  - C: go to SETING_CODE (password change), clear buffer. C wins over a timer expiry in the same cycle.
  - All other keys: ignore.
- FREEZED:
  - All keys ignored, including on the expiry cycle; success_input stays 0.
  - Timer at 0: failure_times=0, go to SETCODE_FINISH.
- failure_times:
  - Saturates at 3.
  - Kept across SETCODE_FINISH/INPUTING_PASSWORD round trips.
  - Cleared only by a match, a new password set, freeze expiry, or reset.
- Reset mid-operation: reset overrides everything in the same cycle, including a key event or timer expiry. The stored password is lost.
- The stored password is never driven on any output.

Decomposition:
- Package password_lock_pkg:
  - 3-bit state encodings, shared verbatim with the display block.
  - Key code constants KEY_CONFIRM=4'hA, KEY_BACK=4'hB, KEY_SET=4'hC, KEY_CANCEL=4'hD.
  - Constant MAX_DIGITS=3.
  - Constant MAX_FAIL=3.
- Sub-module lock_timer:
  - TIMER_W down-counter with load and load_value.
  - Outputs a registered expired flag (count==0 while running).
  - Shared by MATCH_SUCCESS and FREEZED.
- Top block holds the FSM, buffer and comparator.

Test Plan (FREEZE_CYCLES=20, SUCCESS_CYCLES=10):
- Set password: C, 1, 2, 3, A -> states 001 then 010. During entry password_input=12'h123 with count 3. success_input pulses 5 times. After A, buffer is 0.
- Entry edits: in SETING_CODE send 4, 5, B, 6, 7, 8 -> password_input=12'h467, count=3. The last digit 8 is ignored with success_input=0. A with count 2 stays in 001.
- Correct match: password 123 stored; keys 1, 2, 3, A -> state 100, failure_times 0. After 10 cycles -> 010. Key C sent at cycle 5 instead -> 001.
- Three wrong entries (999 A, three times) -> failure_times 1, 2, then 3 with state 101. Keys sent during the freeze give no change and no success_input. After 20 cycles -> 010 with failure_times 0.
- Reset mid-entry: reset=0 with count=2 in state 011 -> next cycle state 000, all outputs 0. A digit key is then ignored until C.
- Cancel: in 011 with count 2, D -> state 010, count 0. In 001 with no stored password, D -> 000.

Source files
------------

// File: rtl/password_lock_pkg.sv
// Shared constants for the password-lock controller and its display block.
package password_lock_pkg;

    localparam logic [2:0] ST_IDLE              = 3'b000;
    localparam logic [2:0] ST_SETING_CODE       = 3'b001;
    localparam logic [2:0] ST_SETCODE_FINISH    = 3'b010;
    localparam logic [2:0] ST_INPUTING_PASSWORD = 3'b011;
    localparam logic [2:0] ST_MATCH_SUCCESS     = 3'b100;
    localparam logic [2:0] ST_FREEZED           = 3'b101;

    localparam logic [3:0] KEY_CONFIRM = 4'hA;
    localparam logic [3:0] KEY_BACK    = 4'hB;
    localparam logic [3:0] KEY_SET     = 4'hC;
    localparam logic [3:0] KEY_CANCEL  = 4'hD;

    localparam int unsigned MAX_DIGITS = 3;
    localparam int unsigned MAX_FAIL   = 3;
    localparam int unsigned BUF_W      = 12;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned FAIL_W     = 2;

    // Write a nibble at digit position idx; position 0 is the most significant nibble.
    function automatic logic [11:0] put_nibble(input logic [11:0] b, input logic [2:0] idx,
                                               input logic [3:0] val);
        logic [11:0] r;
        r = b;
        case (idx)
            3'd0:    r[11:8] = val;
            3'd1:    r[7:4]  = val;
            3'd2:    r[3:0]  = val;
            default: r       = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/password_lock_ctrl_timer.sv
// Loadable down-counter shared by the success hold and the freeze period.
module lock_timer #(
    parameter int unsigned TIMER_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               run,
    output logic               expired
);

    logic [TIMER_W-1:0] count;

    // expired rises in the same edge that the counter reaches zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (load) begin
            count   <= load_value;
            expired <= (load_value == '0);
        end else if (run && count != '0) begin
            count   <= count - TIMER_W'(1);
            expired <= (count == TIMER_W'(1));
        end
    end

endmodule

// File: rtl/password_lock_ctrl.sv
// Password-lock main controller: key sequencing, entry buffer, comparison and lockout.
module password_lock_ctrl
    import password_lock_pkg::*;
#(
    parameter int unsigned FREEZE_CYCLES  = 500_000_000,
    parameter int unsigned SUCCESS_CYCLES = 300_000_000,
    parameter int unsigned TIMER_W        = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [2:0]  current_work_state,
    output logic [11:0] password_input,
    output logic [2:0]  input_count,
    output logic [1:0]  failure_times,
    output logic        success_input
);

    localparam logic [CNT_W-1:0]  DIGITS_FULL = CNT_W'(MAX_DIGITS);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT  = FAIL_W'(MAX_FAIL);

    logic [2:0]         state_nxt;
    logic [BUF_W-1:0]   buf_nxt, edit_buf, stored_pw, pw_nxt;
    logic [CNT_W-1:0]   cnt_nxt, edit_cnt;
    logic [FAIL_W-1:0]  fail_nxt, fail_inc;
    logic               acc_nxt, pw_valid, pwv_nxt, edit_ok;
    logic               tmr_load, tmr_run, tmr_expired;
    logic [TIMER_W-1:0] tmr_value;
    logic               is_digit, is_confirm, is_back, is_set, is_cancel;

    assign is_digit   = key_valid && (key_code <= 4'd9);
    assign is_confirm = key_valid && (key_code == KEY_CONFIRM);
    assign is_back    = key_valid && (key_code == KEY_BACK);
    assign is_set     = key_valid && (key_code == KEY_SET);
    assign is_cancel  = key_valid && (key_code == KEY_CANCEL);
    assign fail_inc   = (failure_times == FAIL_LIMIT) ? failure_times : failure_times + FAIL_W'(1);
    assign tmr_run    = (current_work_state == ST_MATCH_SUCCESS) || (current_work_state == ST_FREEZED);

    lock_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .run        (tmr_run),
        .expired    (tmr_expired)
    );

    // Digit append / backspace shared by password setting and password entry
    always_comb begin
        edit_ok  = 1'b0;
        edit_buf = password_input;
        edit_cnt = input_count;
        if (is_digit && input_count < DIGITS_FULL) begin
            edit_ok  = 1'b1;
            edit_buf = put_nibble(password_input, input_count, key_code);
            edit_cnt = input_count + CNT_W'(1);
        end else if (is_back && input_count != '0) begin
            edit_ok  = 1'b1;
            edit_buf = put_nibble(password_input, input_count - CNT_W'(1), 4'h0);
            edit_cnt = input_count - CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = current_work_state;
        buf_nxt   = password_input;
        cnt_nxt   = input_count;
        fail_nxt  = failure_times;
        acc_nxt   = 1'b0;
        pw_nxt    = stored_pw;
        pwv_nxt   = pw_valid;
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (current_work_state)
            ST_IDLE: begin
                if (is_set) begin
                    state_nxt = ST_SETING_CODE;
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                    acc_nxt   = 1'b1;
                end
            end
            ST_SETING_CODE: begin
                if (edit_ok) begin
                    buf_nxt = edit_buf;
                    cnt_nxt = edit_cnt;
                    acc_nxt = 1'b1;
                end else if (is_confirm && input_count == DIGITS_FULL) begin
                    pw_nxt    = password_input;
                    pwv_nxt   = 1'b1;
                    fail_nxt  = '0;
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_SETCODE_FINISH;
                    acc_nxt   = 1'b1;
                end else if (is_cancel) begin
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = pw_valid ? ST_SETCODE_FINISH : ST_IDLE;
                    acc_nxt   = 1'b1;
                end
            end
            ST_SETCODE_FINISH: begin
                if (is_digit) begin
                    buf_nxt   = {key_code, 8'h00};
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = ST_INPUTING_PASSWORD;
                    acc_nxt   = 1'b1;
                end
            end
            ST_INPUTING_PASSWORD: begin
                if (edit_ok) begin
                    buf_nxt = edit_buf;
                    cnt_nxt = edit_cnt;
                    acc_nxt = 1'b1;
                end else if (is_confirm && input_count == DIGITS_FULL) begin
                    buf_nxt = '0;
                    cnt_nxt = '0;
                    acc_nxt = 1'b1;
                    if (password_input == stored_pw) begin
                        fail_nxt  = '0;
                        tmr_load  = 1'b1;
                        tmr_value = TIMER_W'(SUCCESS_CYCLES - 1);
                        state_nxt = ST_MATCH_SUCCESS;
                    end else begin
                        fail_nxt = fail_inc;
                        if (fail_inc == FAIL_LIMIT) begin
                            tmr_load  = 1'b1;
                            tmr_value = TIMER_W'(FREEZE_CYCLES - 1);
                            state_nxt = ST_FREEZED;
                        end else begin
                            state_nxt = ST_SETCODE_FINISH;
                        end
                    end
                end else if (is_cancel) begin
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_SETCODE_FINISH;
                    acc_nxt   = 1'b1;
                end
            end
            ST_MATCH_SUCCESS: begin
                // A password change request takes priority over the hold ending
                if (is_set) begin
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_SETING_CODE;
                    acc_nxt   = 1'b1;
                end else if (tmr_expired) begin
                    state_nxt = ST_SETCODE_FINISH;
                end
            end
            ST_FREEZED: begin
                if (tmr_expired) begin
                    fail_nxt  = '0;
                    state_nxt = ST_SETCODE_FINISH;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            current_work_state <= ST_IDLE;
            password_input     <= '0;
            input_count        <= '0;
            failure_times      <= '0;
            success_input      <= 1'b0;
            stored_pw          <= '0;
            pw_valid           <= 1'b0;
        end else begin
            current_work_state <= state_nxt;
            password_input     <= buf_nxt;
            input_count        <= cnt_nxt;
            failure_times      <= fail_nxt;
            success_input      <= acc_nxt;
            stored_pw          <= pw_nxt;
            pw_valid           <= pwv_nxt;
        end
    end

endmodule
